// File: rtl/csr_regfile_pkg.sv
// Shared CSR address map, mstatus/mie/mip bit positions and decode helpers
// for the machine-mode CSR register file.
package csr_regfile_pkg;

  localparam logic [11:0] CSR_MSTATUS_ADDR  = 12'h300;
  localparam logic [11:0] CSR_MISA_ADDR     = 12'h301;
  localparam logic [11:0] CSR_MIE_ADDR      = 12'h304;
  localparam logic [11:0] CSR_MTVEC_ADDR    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH_ADDR = 12'h340;
  localparam logic [11:0] CSR_MEPC_ADDR     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE_ADDR   = 12'h342;
  localparam logic [11:0] CSR_MTVAL_ADDR    = 12'h343;
  localparam logic [11:0] CSR_MIP_ADDR      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE_ADDR   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET_ADDR = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH_ADDR  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH_ADDR= 12'hB82;
  localparam logic [11:0] CSR_MHARTID_ADDR  = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;

  localparam int MIP_MSIP_BIT = 3;
  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MEIP_BIT = 11;

  localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

  function automatic logic csr_mapped(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS_ADDR, CSR_MISA_ADDR, CSR_MIE_ADDR, CSR_MTVEC_ADDR,
      CSR_MSCRATCH_ADDR, CSR_MEPC_ADDR, CSR_MCAUSE_ADDR, CSR_MTVAL_ADDR,
      CSR_MIP_ADDR, CSR_MCYCLE_ADDR, CSR_MINSTRET_ADDR, CSR_MCYCLEH_ADDR,
      CSR_MINSTRETH_ADDR, CSR_MHARTID_ADDR: csr_mapped = 1'b1;
      default:                              csr_mapped = 1'b0;
    endcase
  endfunction

  // Address bits [11:10]==2'b11 encode the architecturally read-only space.
  function automatic logic csr_writable(input logic [11:0] addr);
    csr_writable = csr_mapped(addr) && (addr[11:10] != 2'b11);
  endfunction

  function automatic logic [31:0] align4(input logic [31:0] v);
    align4 = {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/csr_regfile_counter64.sv
// 64-bit free-running counter with independently loadable halves; a load
// takes precedence over the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) cnt[31:0]  <= wdata;
      if (wr_hi) cnt[63:32] <= wdata;
    end else if (inc) begin
      cnt <= cnt + 64'd1;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// RV32 machine-mode CSR register file: combinational read port, writeback
// commit port, trap/mret state, cycle/instret counters and irq generation.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_rd_addr,
  output logic [31:0] csr_rdata,
  output logic        csr_rd_illegal,
  input  logic        csr_wr_en,
  input  logic [11:0] csr_wr_addr,
  input  logic [31:0] csr_wdata,
  output logic        csr_wr_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic        instret_pulse,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_sw,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_take
);

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [31:0] mip;
  logic [31:0] mstatus;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic        wr_ok;

  always_comb begin
    mip = 32'd0;
    mip[MIP_MSIP_BIT] = irq_sw;
    mip[MIP_MTIP_BIT] = irq_timer;
    mip[MIP_MEIP_BIT] = irq_ext;
  end

  always_comb begin
    mstatus = 32'd0;
    mstatus[MSTATUS_MIE_BIT]                    = mstatus_mie;
    mstatus[MSTATUS_MPIE_BIT]                   = mstatus_mpie;
    mstatus[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO]    = 2'b11;
  end

  assign csr_wr_illegal = csr_wr_en && !csr_writable(csr_wr_addr);
  // A trap in the same cycle discards the whole pending write.
  assign wr_ok = csr_wr_en && csr_writable(csr_wr_addr) && !trap_valid;

  always_comb begin
    csr_rdata      = 32'd0;
    csr_rd_illegal = 1'b0;
    case (csr_rd_addr)
      CSR_MSTATUS_ADDR:   csr_rdata = mstatus;
      CSR_MISA_ADDR:      csr_rdata = MISA_VAL;
      CSR_MIE_ADDR:       csr_rdata = mie;
      CSR_MTVEC_ADDR:     csr_rdata = mtvec;
      CSR_MSCRATCH_ADDR:  csr_rdata = mscratch;
      CSR_MEPC_ADDR:      csr_rdata = mepc;
      CSR_MCAUSE_ADDR:    csr_rdata = mcause;
      CSR_MTVAL_ADDR:     csr_rdata = mtval;
      CSR_MIP_ADDR:       csr_rdata = mip;
      CSR_MCYCLE_ADDR:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH_ADDR:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET_ADDR:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH_ADDR: csr_rdata = minstret[63:32];
      CSR_MHARTID_ADDR:   csr_rdata = HART_ID;
      default:            csr_rd_illegal = 1'b1;
    endcase
  end

  // Priority: trap > mret > software write for mstatus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_valid) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_valid) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_ok && csr_wr_addr == CSR_MSTATUS_ADDR) begin
      mstatus_mie  <= csr_wdata[MSTATUS_MIE_BIT];
      mstatus_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 32'd0;
      mtvec    <= MTVEC_RST;
      mscratch <= 32'd0;
      mepc     <= 32'd0;
      mcause   <= 32'd0;
      mtval    <= 32'd0;
    end else if (trap_valid) begin
      mepc   <= align4(trap_pc);
      mcause <= trap_cause;
      mtval  <= trap_tval;
    end else if (wr_ok) begin
      case (csr_wr_addr)
        CSR_MIE_ADDR:      mie      <= csr_wdata & MIE_WMASK;
        CSR_MTVEC_ADDR:    mtvec    <= align4(csr_wdata);
        CSR_MSCRATCH_ADDR: mscratch <= csr_wdata;
        CSR_MEPC_ADDR:     mepc     <= align4(csr_wdata);
        CSR_MCAUSE_ADDR:   mcause   <= csr_wdata;
        CSR_MTVAL_ADDR:    mtval    <= csr_wdata;
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_take <= 1'b0;
    else        irq_take <= mstatus_mie && |(mip & mie);
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (wr_ok && csr_wr_addr == CSR_MCYCLE_ADDR),
    .wr_hi (wr_ok && csr_wr_addr == CSR_MCYCLEH_ADDR),
    .wdata (csr_wdata),
    .cnt   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instret_pulse),
    .wr_lo (wr_ok && csr_wr_addr == CSR_MINSTRET_ADDR),
    .wr_hi (wr_ok && csr_wr_addr == CSR_MINSTRETH_ADDR),
    .wdata (csr_wdata),
    .cnt   (minstret)
  );

  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed-vector bench for csr_regfile with hand-computed expectations.
module tb_csr_regfile;

  localparam logic [31:0] HART = 32'd3;
  localparam logic [31:0] MISA = 32'h4000_0100;
  localparam logic [31:0] TVEC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rdata;
  logic        csr_rd_illegal;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wr_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        instret_pulse;
  logic        irq_ext;
  logic        irq_timer;
  logic        irq_sw;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        irq_take;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  csr_regfile #(.HART_ID(HART), .MISA_VAL(MISA), .MTVEC_RST(TVEC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr_rd_addr    (csr_rd_addr),
    .csr_rdata      (csr_rdata),
    .csr_rd_illegal (csr_rd_illegal),
    .csr_wr_en      (csr_wr_en),
    .csr_wr_addr    (csr_wr_addr),
    .csr_wdata      (csr_wdata),
    .csr_wr_illegal (csr_wr_illegal),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .mret_valid     (mret_valid),
    .instret_pulse  (instret_pulse),
    .irq_ext        (irq_ext),
    .irq_timer      (irq_timer),
    .irq_sw         (irq_sw),
    .mtvec_o        (mtvec_o),
    .mepc_o         (mepc_o),
    .irq_take       (irq_take)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
    csr_rd_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_wr_en   = 1'b1;
    csr_wr_addr = a;
    csr_wdata   = d;
  endtask

  initial begin
    rst_n = 1'b0;
    csr_rd_addr = '0; csr_wr_en = 1'b0; csr_wr_addr = '0; csr_wdata = '0;
    trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mret_valid = 1'b0; instret_pulse = 1'b0;
    irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    rd(12'h305, "rst_mtvec", TVEC);
    rd(12'h300, "rst_mstatus", 32'h0000_1800);
    rd(12'hF14, "rst_mhartid", HART);
    rd(12'h301, "rst_misa", MISA);
    rd(12'h7C0, "unmapped_rdata", 32'd0);
    chk("unmapped_illegal", {31'd0, csr_rd_illegal}, 32'd1);
    chk("rst_irq_take", {31'd0, irq_take}, 32'd0);
    chk("rst_mepc_o", mepc_o, 32'd0);

    // write / readback
    wr(12'h340, 32'hDEAD_BEEF);
    rd(12'h340, "mscratch_same_cycle", 32'd0);
    chk("mscratch_wr_legal", {31'd0, csr_wr_illegal}, 32'd0);
    tick();
    csr_wr_en = 1'b0;
    rd(12'h340, "mscratch_next_cycle", 32'hDEAD_BEEF);
    wr(12'h305, 32'h8000_0103);
    tick();
    csr_wr_en = 1'b0;
    #1;
    chk("mtvec_o_masked", mtvec_o, 32'h8000_0100);

    // trap beats a simultaneous write
    wr(12'h300, 32'h0000_0008);
    tick();
    csr_wr_en = 1'b0;
    rd(12'h300, "mstatus_mie_set", 32'h0000_1808);
    trap_valid = 1'b1; trap_pc = 32'h0000_1234; trap_cause = 32'h8000_0007;
    trap_tval = 32'h0000_0ABC;
    wr(12'h341, 32'h5555_5555);
    tick();
    trap_valid = 1'b0; csr_wr_en = 1'b0;
    #1;
    chk("trap_mepc_o", mepc_o, 32'h0000_1234);
    rd(12'h342, "trap_mcause", 32'h8000_0007);
    rd(12'h343, "trap_mtval", 32'h0000_0ABC);
    rd(12'h300, "trap_mstatus", 32'h0000_1880);
    // mret wins over a concurrent mstatus write
    mret_valid = 1'b1;
    wr(12'h300, 32'h0000_0000);
    tick();
    mret_valid = 1'b0; csr_wr_en = 1'b0;
    rd(12'h300, "mret_mstatus", 32'h0000_1888);

    // interrupt path
    wr(12'h304, 32'h0000_0080);
    tick();
    csr_wr_en = 1'b0;
    irq_timer = 1'b1;
    rd(12'h344, "mip_same_cycle", 32'h0000_0080);
    chk("irq_take_not_yet", {31'd0, irq_take}, 32'd0);
    tick();
    chk("irq_take_asserted", {31'd0, irq_take}, 32'd1);
    wr(12'h304, 32'h0000_0000);
    tick();
    csr_wr_en = 1'b0;
    tick();
    chk("irq_take_mie_cleared", {31'd0, irq_take}, 32'd0);
    wr(12'h304, 32'h0000_0080);
    tick();
    csr_wr_en = 1'b0;
    tick();
    chk("irq_take_reenabled", {31'd0, irq_take}, 32'd1);
    trap_valid = 1'b1; trap_pc = 32'h0000_2002; trap_cause = 32'h8000_0007;
    tick();
    trap_valid = 1'b0;
    #1;
    chk("trap_pc_aligned", mepc_o, 32'h0000_2000);
    tick();
    chk("irq_take_after_trap", {31'd0, irq_take}, 32'd0);
    irq_timer = 1'b0;

    // 64-bit cycle counter wrap
    wr(12'hB80, 32'hFFFF_FFFF);
    tick();
    wr(12'hB00, 32'hFFFF_FFFE);
    tick();
    csr_wr_en = 1'b0;
    rd(12'hB00, "mcycle_loaded", 32'hFFFF_FFFE);
    rd(12'hB80, "mcycleh_loaded", 32'hFFFF_FFFF);
    tick(); tick();
    rd(12'hB00, "mcycle_wrapped", 32'd0);
    rd(12'hB80, "mcycleh_wrapped", 32'd0);

    // minstret: write beats a coincident retire pulse
    wr(12'hB02, 32'h0000_0010);
    instret_pulse = 1'b1;
    tick();
    csr_wr_en = 1'b0;
    instret_pulse = 1'b0;
    rd(12'hB02, "minstret_write_wins", 32'h0000_0010);
    instret_pulse = 1'b1;
    tick();
    instret_pulse = 1'b0;
    rd(12'hB02, "minstret_increment", 32'h0000_0011);
    rd(12'hB82, "minstreth_hold", 32'd0);

    // writes to read-only space are flagged and dropped
    wr(12'hF14, 32'h0000_00FF);
    #1;
    chk("mhartid_wr_illegal", {31'd0, csr_wr_illegal}, 32'd1);
    tick();
    csr_wr_en = 1'b0;
    rd(12'hF14, "mhartid_unchanged", HART);
    wr(12'h7C0, 32'h1);
    #1;
    chk("unmapped_wr_illegal", {31'd0, csr_wr_illegal}, 32'd1);
    csr_wr_en = 1'b0;

    // asynchronous reset mid-operation
    wr(12'h340, 32'h1234_5678);
    #2;
    rst_n = 1'b0;
    #1;
    csr_wr_en = 1'b0;
    rd(12'h340, "async_rst_mscratch", 32'd0);
    chk("async_rst_mtvec_o", mtvec_o, TVEC);
    tick();
    rst_n = 1'b1;
    tick();
    rd(12'h300, "post_rst_mstatus", 32'h0000_1800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine-mode CSR register file, RV32: the storage end of the CSR read-modify-write path.
- Supplies the current CSR value (csr_rdata) to the execute-stage CSR operator, and commits the operator's result (csr_wdata) at writeback.
- Also owns trap entry/return state (mstatus, mepc, mcause, mtval), the 64-bit cycle/instret counters and interrupt-pending generation toward the core.

Parameters:
- HART_ID, 0, value returned by mhartid.
- MISA_VAL, 32'h4000_0100, value returned by misa (RV32I); read-only.
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_rd_addr  in  12  CSR address read in execute
- csr_rdata  out  32  combinational read data (Op2 of the CSR operator)
- csr_rd_illegal  out  1  csr_rd_addr not implemented
- csr_wr_en  in  1  commit a CSR write this cycle
- csr_wr_addr  in  12  write address
- csr_wdata  in  32  new value (CSR operator result)
- csr_wr_illegal  out  1  combinational: write to unimplemented or read-only CSR (addr[11:10]==2'b11 or unmapped)
- trap_valid  in  1  take trap this cycle
- trap_cause  in  32  mcause value (bit31 = interrupt)
- trap_pc  in  32  PC saved to mepc
- trap_tval  in  32  saved to mtval
- mret_valid  in  1  execute mret this cycle
- instret_pulse  in  1  one instruction retired
- irq_ext, irq_timer, irq_sw  in  1 each  level interrupt sources
- mtvec_o  out  32  trap vector to fetch
- mepc_o  out  32  return address to fetch
- irq_take  out  1  mstatus.MIE & |(mip & mie)

Behaviour:
- Implemented CSRs: mstatus 0x300 (only MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11), misa 0x301, mie 0x304 (bits 3,7,11 writable), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (read-only image of irq inputs: MSIP bit3, MTIP bit7, MEIP bit11), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, mhartid 0xF14.
- Unmapped reads return 0 with csr_rd_illegal=1. Illegal writes are dropped.
- Reset values:
  - mstatus MIE=0, MPIE=0.
  - mie=0, mtvec=MTVEC_RST, mscratch=0, mepc=0, mcause=0, mtval=0.
  - Counters = 0.
  - irq_take=0.
- Read: purely combinational, zero latency.
- Write: commits on the rising clk edge, visible to reads from the next cycle. A same-cycle read of the written address returns the old value; forwarding is the pipeline's job.
- Field masking: mtvec[1:0] and mepc[1:0] are forced to 0 on every write and on trap capture.
- Trap (trap_valid=1):
  - mepc<=trap_pc, mcause<=trap_cause, mtval<=trap_tval.
  - MPIE<=MIE, MIE<=0.
  - Trap takes priority over a simultaneous csr_wr_en; that write is dropped entirely.
- mret (mret_valid=1): MIE<=MPIE, MPIE<=1. If trap_valid is also 1, the trap wins and mret is ignored.
- mret with csr_wr_en to mstatus in the same cycle: the mret update wins; the other registers accept writes normally.
- mcycle:
  - Increments by 1 every cycle, 64-bit, wraps from 2^64-1 to 0.
  - A write to the low or high half loads that half and suppresses the increment for that cycle; the other half holds.
- minstret: same rules, but increments only when instret_pulse=1.
- irq_take: registered, so it asserts one cycle after the qualifying condition appears. Deasserts the cycle after trap_valid because MIE clears.
- Reset mid-operation: all state returns to reset values asynchronously; a pending write or trap is lost.

Decomposition:
- CSR addresses (CSR_MSTATUS_ADDR … CSR_MHARTID_ADDR), mstatus bit indices and mie/mip bit indices go in the shared risc_v_defines.vh alongside the existing DECINFO_CSR defines.
- One sub-module, csr_counter64:
  - clk, rst_n, inc, wr_lo, wr_hi, wdata[31:0], cnt[63:0].
  - Instantiated twice (mcycle, minstret).

Test Plan:
- Reset: after rst_n deasserts, read 0x305 -> MTVEC_RST, 0x300 -> 32'h0000_1800, 0xF14 -> HART_ID; read 0x7C0 -> 0 with csr_rd_illegal=1.
- Write/readback: wr 0x340=32'hDEAD_BEEF -> same-cycle read returns 0, next cycle returns 32'hDEAD_BEEF. Wr 0x305=32'h8000_0103 -> mtvec_o=32'h8000_0100.
- Trap vs write: MIE=1; assert trap_valid (pc 32'h0000_1234, cause 32'h8000_0007) with csr_wr_en to 0x341=32'h5555_5555 -> mepc=32'h0000_1234, mcause=32'h8000_0007, MIE=0, MPIE=1. The next mret restores MIE=1.
- Interrupt: mie=32'h80, MIE=1, raise irq_timer -> mip reads 32'h80 the same cycle, irq_take=1 one cycle later. Clearing mie bit7 -> irq_take=0 on the following cycle.
- Counter wrap/write: wr mcycleh=32'hFFFF_FFFF, then mcycle=32'hFFFF_FFFE -> two cycles later {mcycleh,mcycle}=0. A write to minstret coincident with instret_pulse -> the written value holds, no increment.
- Read-only write: csr_wr_en to 0xF14 -> csr_wr_illegal=1, mhartid unchanged.
